// File: rtl/cam_pwr_seq_pkg.sv
// Shared types and timing constants for the camera power / I2C bring-up sequencer.
package cam_pwr_seq_pkg;

    // The strobe is clk_100 divided by NUM_CLK_FOR_400kHZ, so one second is STROBE_HZ ticks.
    localparam int NUM_CLK_FOR_400kHZ = 250;
    localparam int STROBE_HZ          = 100_000_000 / NUM_CLK_FOR_400kHZ;

    localparam int CAM_TICK_W    = 20;
    localparam int CAM_T_PWR     = 2 * STROBE_HZ;
    localparam int CAM_T_I2C     = STROBE_HZ;
    localparam int CAM_T_TMO     = STROBE_HZ;
    localparam int CAM_T_OFF     = STROBE_HZ / 2;
    localparam int CAM_MAX_RETRY = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PWR_WAIT = 3'd1,
        ST_I2C_WAIT = 3'd2,
        ST_INIT     = 3'd3,
        ST_RUN      = 3'd4,
        ST_BACKOFF  = 3'd5,
        ST_FAIL     = 3'd6
    } cam_seq_state_t;

    typedef logic [CAM_TICK_W-1:0] cam_tick_t;

    typedef struct packed {
        logic cam_en;
        logic i2c_areset_n;
        logic ready;
        logic fail;
    } cam_out_t;

    // All-zero is the IDLE/reset output pattern.
    function automatic cam_out_t cam_decode(cam_seq_state_t st);
        cam_out_t o;
        o = '0;
        case (st)
            ST_PWR_WAIT: o.cam_en = 1'b1;
            ST_I2C_WAIT,
            ST_INIT: begin
                o.cam_en       = 1'b1;
                o.i2c_areset_n = 1'b1;
            end
            ST_RUN: begin
                o.cam_en       = 1'b1;
                o.i2c_areset_n = 1'b1;
                o.ready        = 1'b1;
            end
            ST_FAIL: o.fail = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cam_pwr_seq_tick_timer.sv
// Strobe-gated dwell counter shared by all timed states; expire fires on the strobe
// that completes the dwell, i.e. while the count equals the programmed last value.
module seq_tick_timer
    import cam_pwr_seq_pkg::*;
#(
    parameter int TICK_W = CAM_TICK_W
) (
    input  logic              clk_100,
    input  logic              srst0,
    input  logic              strobe,
    input  logic              en,
    input  logic              clr,
    input  logic [TICK_W-1:0] last,
    output logic              expire
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && strobe) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state flops use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_100 or posedge srst0) begin
        if (srst0) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && strobe && (cnt_q == last);

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera power-up and I2C-master bring-up sequencer with power-cycle retry and sticky fail.
module cam_pwr_seq
    import cam_pwr_seq_pkg::*;
#(
    parameter int T_PWR_TICKS = CAM_T_PWR,
    parameter int T_I2C_TICKS = CAM_T_I2C,
    parameter int T_INIT_TMO  = CAM_T_TMO,
    parameter int T_OFF_TICKS = CAM_T_OFF,
    parameter int MAX_RETRY   = CAM_MAX_RETRY,
    parameter int TICK_W      = CAM_TICK_W
) (
    input  logic       clk_100,
    input  logic       srst0,
    input  logic       strobe_400kHz,
    input  logic       start,
    input  logic       i2c_done,
    input  logic       i2c_err,
    output logic       cam_en,
    output logic       i2c_areset_n,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam logic [TICK_W-1:0] LAST_PWR  = TICK_W'(T_PWR_TICKS - 1);
    localparam logic [TICK_W-1:0] LAST_I2C  = TICK_W'(T_I2C_TICKS - 1);
    localparam logic [TICK_W-1:0] LAST_TMO  = TICK_W'(T_INIT_TMO - 1);
    localparam logic [TICK_W-1:0] LAST_OFF  = TICK_W'(T_OFF_TICKS - 1);
    localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);

    cam_seq_state_t    state_q;
    cam_seq_state_t    state_d;
    logic [1:0]        retry_cnt_q;
    logic [1:0]        retry_cnt_d;
    cam_out_t          out_q;
    cam_out_t          out_d;

    logic              tmr_en;
    logic              tmr_clr;
    logic              tmr_expire;
    logic [TICK_W-1:0] tmr_last;

    seq_tick_timer #(
        .TICK_W (TICK_W)
    ) u_timer (
        .clk_100 (clk_100),
        .srst0   (srst0),
        .strobe  (strobe_400kHz),
        .en      (tmr_en),
        .clr     (tmr_clr),
        .last    (tmr_last),
        .expire  (tmr_expire)
    );

    always_comb begin
        tmr_en   = 1'b1;
        tmr_last = '0;
        case (state_q)
            ST_PWR_WAIT: tmr_last = LAST_PWR;
            ST_I2C_WAIT: tmr_last = LAST_I2C;
            ST_INIT:     tmr_last = LAST_TMO;
            ST_BACKOFF:  tmr_last = LAST_OFF;
            default:     tmr_en   = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        if (!start) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     state_d = ST_PWR_WAIT;
                ST_PWR_WAIT: if (tmr_expire) state_d = ST_I2C_WAIT;
                ST_I2C_WAIT: if (tmr_expire) state_d = ST_INIT;
                ST_INIT: begin
                    // Error beats done, done beats a coincident timeout.
                    if (i2c_err || (tmr_expire && !i2c_done)) begin
                        if (retry_cnt_q < RETRY_MAX) begin
                            state_d     = ST_BACKOFF;
                            retry_cnt_d = retry_cnt_q + 2'd1;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end else if (i2c_done) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN:      state_d = ST_RUN;
                ST_BACKOFF:  if (tmr_expire) state_d = ST_PWR_WAIT;
                ST_FAIL:     state_d = ST_FAIL;
                default:     state_d = ST_IDLE;
            endcase
        end
        if (state_d == ST_IDLE) begin
            retry_cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    assign out_d   = cam_decode(state_d);
    assign tmr_clr = (state_d != state_q);

    always_ff @(posedge clk_100 or posedge srst0) begin
        if (srst0) begin
            state_q     <= ST_IDLE;
            retry_cnt_q <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            out_q       <= out_d;
        end
    end

    assign cam_en       = out_q.cam_en;
    assign i2c_areset_n = out_q.i2c_areset_n;
    assign ready        = out_q.ready;
    assign fail         = out_q.fail;
    assign retry_cnt    = retry_cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed test-plan scenarios followed by a random run, all checked every cycle against
// a phase/strobe-count reference model of the sequencer.
module tb_cam_pwr_seq;

    localparam int P_PWR  = 4;
    localparam int P_I2C  = 3;
    localparam int P_TMO  = 6;
    localparam int P_OFF  = 2;
    localparam int P_MAXR = 2;

    localparam int PH_IDLE = 0;
    localparam int PH_PWR  = 1;
    localparam int PH_I2C  = 2;
    localparam int PH_INIT = 3;
    localparam int PH_RUN  = 4;
    localparam int PH_OFF  = 5;
    localparam int PH_FAIL = 6;

    logic       clk_100 = 1'b0;
    logic       srst0;
    logic       strobe_400kHz;
    logic       start;
    logic       i2c_done;
    logic       i2c_err;
    logic       cam_en;
    logic       i2c_areset_n;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: which phase we are in, strobes seen in it, retries used.
    int m_phase;
    int m_strobes;
    int m_retry;

    bit rand_mode = 1'b0;
    int stb_ph    = 3;
    int strobes_in [8];

    always #5 clk_100 = ~clk_100;

    cam_pwr_seq #(
        .T_PWR_TICKS (P_PWR),
        .T_I2C_TICKS (P_I2C),
        .T_INIT_TMO  (P_TMO),
        .T_OFF_TICKS (P_OFF),
        .MAX_RETRY   (P_MAXR),
        .TICK_W      (20)
    ) dut (
        .clk_100       (clk_100),
        .srst0         (srst0),
        .strobe_400kHz (strobe_400kHz),
        .start         (start),
        .i2c_done      (i2c_done),
        .i2c_err       (i2c_err),
        .cam_en        (cam_en),
        .i2c_areset_n  (i2c_areset_n),
        .ready         (ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .state_o       (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go(input int ph);
        m_phase   = ph;
        m_strobes = 0;
    endtask

    task automatic model_reset();
        go(PH_IDLE);
        m_retry = 0;
    endtask

    // A timed phase ends on the strobe that makes its count reach the dwell length.
    task automatic dwell(input bit stb, input int len, input int nxt);
        if (stb) begin
            if (m_strobes + 1 == len) go(nxt);
            else m_strobes++;
        end
    endtask

    task automatic model_step(input bit s_start, input bit s_stb, input bit s_done, input bit s_err);
        bit tmo;
        if (!s_start) begin
            model_reset();
            return;
        end
        case (m_phase)
            PH_IDLE: go(PH_PWR);
            PH_PWR:  dwell(s_stb, P_PWR, PH_I2C);
            PH_I2C:  dwell(s_stb, P_I2C, PH_INIT);
            PH_OFF:  dwell(s_stb, P_OFF, PH_PWR);
            PH_INIT: begin
                tmo = s_stb && (m_strobes + 1 == P_TMO);
                if (s_err || (tmo && !s_done)) begin
                    if (m_retry < P_MAXR) begin
                        m_retry++;
                        go(PH_OFF);
                    end else begin
                        go(PH_FAIL);
                    end
                end else if (s_done) begin
                    go(PH_RUN);
                end else if (s_stb) begin
                    m_strobes++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        bit powered;
        powered = (m_phase >= PH_PWR) && (m_phase <= PH_RUN);
        check({tag, "_state"},  state_o,      m_phase);
        check({tag, "_cam_en"}, cam_en,       powered);
        check({tag, "_arst_n"}, i2c_areset_n, powered && (m_phase != PH_PWR));
        check({tag, "_ready"},  ready,        m_phase == PH_RUN);
        check({tag, "_fail"},   fail,         m_phase == PH_FAIL);
        check({tag, "_retry"},  retry_cnt,    m_retry);
    endtask

    // One clock: sample the applied inputs, step the model, compare, then set up the next cycle.
    task automatic tick();
        bit s_start, s_stb, s_done, s_err, s_rst;
        s_start = start;
        s_stb   = strobe_400kHz;
        s_done  = i2c_done;
        s_err   = i2c_err;
        s_rst   = srst0;
        if (s_stb) strobes_in[state_o]++;
        @(posedge clk_100);
        #1;
        if (s_rst) model_reset();
        else model_step(s_start, s_stb, s_done, s_err);
        check_outputs("cyc");
        i2c_done = 1'b0;
        i2c_err  = 1'b0;
        if (rand_mode) begin
            strobe_400kHz = ($urandom_range(0, 2) == 0);
        end else begin
            stb_ph        = (stb_ph + 1) % 4;
            strobe_400kHz = (stb_ph == 0);
        end
    endtask

    task automatic clear_strobes();
        for (int i = 0; i < 8; i++) strobes_in[i] = 0;
    endtask

    task automatic wait_phase(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && m_phase != target; i++) tick();
        check(tag, state_o, target);
    endtask

    initial begin
        srst0         = 1'b1;
        start         = 1'b0;
        i2c_done      = 1'b0;
        i2c_err       = 1'b0;
        strobe_400kHz = 1'b0;
        model_reset();
        clear_strobes();
        repeat (3) tick();
        check("rst_state", state_o, PH_IDLE);
        srst0 = 1'b0;
        repeat (2) tick();

        // 1. Nominal bring-up.
        start = 1'b1;
        clear_strobes();
        tick();
        check("s1_cam_en_1clk", cam_en, 1'b1);
        wait_phase("s1_reach_i2c", PH_I2C, 100);
        check("s1_pwr_strobes", strobes_in[PH_PWR], P_PWR);
        wait_phase("s1_reach_init", PH_INIT, 100);
        check("s1_i2c_strobes", strobes_in[PH_I2C], P_I2C);
        repeat (4) tick();
        i2c_done = 1'b1;
        tick();
        check("s1_ready", ready, 1'b1);
        check("s1_retry", retry_cnt, 2'd0);
        repeat (3) tick();

        // 2. Two errors then success.
        start = 1'b0;
        tick();
        start = 1'b1;
        clear_strobes();
        for (int k = 0; k < 2; k++) begin
            wait_phase("s2_reach_init", PH_INIT, 100);
            i2c_err = 1'b1;
            tick();
            check("s2_backoff", state_o, PH_OFF);
            check("s2_cam_off", cam_en, 1'b0);
        end
        wait_phase("s2_reach_init3", PH_INIT, 100);
        i2c_done = 1'b1;
        tick();
        check("s2_ready", ready, 1'b1);
        check("s2_retry", retry_cnt, 2'd2);
        check("s2_off_strobes", strobes_in[PH_OFF], 2 * P_OFF);

        // 3. Timeout exhaustion.
        start = 1'b0;
        tick();
        start = 1'b1;
        clear_strobes();
        wait_phase("s3_reach_fail", PH_FAIL, 400);
        check("s3_init_strobes", strobes_in[PH_INIT], (P_MAXR + 1) * P_TMO);
        check("s3_fail", fail, 1'b1);
        check("s3_state", state_o, 3'd6);
        repeat (5) tick();
        check("s3_fail_sticky", fail, 1'b1);
        start = 1'b0;
        tick();
        check("s3_fail_clr", fail, 1'b0);
        check("s3_idle", state_o, PH_IDLE);

        // 4. Collisions: done+err -> retry; done on the timeout strobe -> run.
        start = 1'b1;
        wait_phase("s4_reach_init", PH_INIT, 100);
        i2c_done = 1'b1;
        i2c_err  = 1'b1;
        tick();
        check("s4_err_wins", state_o, PH_OFF);
        check("s4_retry", retry_cnt, 2'd1);
        wait_phase("s4_reach_init2", PH_INIT, 100);
        for (int i = 0; i < 100 && !(m_strobes == P_TMO - 1 && strobe_400kHz); i++) tick();
        i2c_done = 1'b1;
        tick();
        check("s4_done_wins", state_o, PH_RUN);

        // 5. Abort mid PWR_WAIT and mid RUN.
        start = 1'b0;
        tick();
        start = 1'b1;
        clear_strobes();
        for (int i = 0; i < 100 && strobes_in[PH_PWR] < 2; i++) tick();
        start = 1'b0;
        tick();
        check("s5_pwr_abort", state_o, PH_IDLE);
        check("s5_pwr_cam_off", cam_en, 1'b0);
        start = 1'b1;
        clear_strobes();
        wait_phase("s5_restart_i2c", PH_I2C, 100);
        check("s5_full_dwell", strobes_in[PH_PWR], P_PWR);
        wait_phase("s5_reach_init", PH_INIT, 100);
        i2c_done = 1'b1;
        tick();
        repeat (2) tick();
        start = 1'b0;
        tick();
        check("s5_run_abort_ready", ready, 1'b0);
        check("s5_run_abort_cam", cam_en, 1'b0);

        // 6. Asynchronous reset in I2C_WAIT.
        start = 1'b1;
        wait_phase("s6_reach_i2c", PH_I2C, 100);
        tick();
        #3 srst0 = 1'b1;
        #1;
        model_reset();
        check("s6_async_cam", cam_en, 1'b0);
        check("s6_async_arst", i2c_areset_n, 1'b0);
        check("s6_async_state", state_o, PH_IDLE);
        tick();
        srst0 = 1'b0;
        clear_strobes();
        tick();
        check("s6_restart", state_o, PH_PWR);
        wait_phase("s6_restart_i2c", PH_I2C, 100);
        check("s6_full_dwell", strobes_in[PH_PWR], P_PWR);

        // Random run against the model.
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (start) begin
                if ($urandom_range(0, 59) == 0) start = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
            end
            i2c_done = ($urandom_range(0, 14) == 0);
            i2c_err  = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
